// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, sizing defaults
// and the word-index to byte-address mapping used on the memory port.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int DEPTH_WORDS_DEFAULT = 1024;
    localparam int HDR_BYTES           = 2;
    localparam int COUNT_W             = 8 * HDR_BYTES;

    // Word index to PC-compatible byte address, zero-extended to 32 bits.
    function automatic logic [31:0] word_addr(input logic [COUNT_W-1:0] idx);
        return {{(30 - COUNT_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = the loader itself.
interface inst_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/inst_loader_word_assembler.sv
// Packs accepted bytes MSB first into a 32-bit word and flags the 4th byte.
// next_word_o already contains the byte being shifted in this cycle.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] next_word_o,
    output logic        word_complete_o
);

    logic [31:0] shreg_q;
    logic [1:0]  byte_idx_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            byte_idx_q <= 2'd0;
        end else if (shift_en_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            shreg_q <= next_word_o;
        end
    end

    assign next_word_o     = {shreg_q[23:0], byte_i};
    assign word_complete_o = shift_en_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: reads a big-endian 16-bit word count followed by MSB-first
// instruction words from a byte stream and writes them to instruction memory.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int TIMEOUT     = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    inst_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    localparam int                   IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]    IDLE_LIMIT  = IDLE_W'(TIMEOUT);
    localparam logic [COUNT_W:0]     DEPTH_LIMIT = (COUNT_W + 1)'(DEPTH_WORDS);

    state_t               state_q;
    logic                 rx_ready_q;
    logic                 imem_we_q;
    logic [31:0]          imem_addr_q;
    logic [31:0]          imem_wdata_q;
    logic                 cpu_rst_q;
    logic                 done_q;
    logic                 err_q;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   word_idx_q;
    logic [COUNT_W-1:0]   word_idx_d;
    logic [COUNT_W-1:0]   hdr_count;
    logic [IDLE_W-1:0]    idle_q;
    logic [IDLE_W-1:0]    idle_d;

    logic                 accept;
    logic                 load_req;
    logic                 timeout_hit;
    logic                 shift_en;
    logic                 asm_clr;
    logic                 word_complete;
    logic [31:0]          next_word;

    always_comb begin
        accept      = bus.rx_valid && rx_ready_q;
        load_req    = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
        idle_d      = idle_q + 1'b1;
        timeout_hit = !accept && (state_q == HDR_LO || state_q == DATA)
                      && (idle_d == IDLE_LIMIT);
        shift_en    = accept && (state_q == DATA);
        // A timeout throws away whatever partial word was being packed.
        asm_clr     = load_req || timeout_hit;
        word_idx_d  = word_idx_q + 1'b1;
        hdr_count   = {count_q[COUNT_W-1:8], bus.rx_data};
    end

    word_assembler u_asm (
        .clk             (clk),
        .rst             (rst),
        .clr_i           (asm_clr),
        .shift_en_i      (shift_en),
        .byte_i          (bus.rx_data),
        .next_word_o     (next_word),
        .word_complete_o (word_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            word_idx_q   <= '0;
            idle_q       <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if (load_req) begin
                state_q    <= HDR_HI;
                rx_ready_q <= 1'b1;
                cpu_rst_q  <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                word_idx_q <= '0;
                idle_q     <= '0;
            end else if (timeout_hit) begin
                state_q    <= ERR;
                rx_ready_q <= 1'b0;
                err_q      <= 1'b1;
                cpu_rst_q  <= 1'b1;
            end else begin
                case (state_q)
                    HDR_HI: begin
                        if (accept) begin
                            count_q[COUNT_W-1:8] <= bus.rx_data;
                            idle_q               <= '0;
                            state_q              <= HDR_LO;
                        end
                    end
                    HDR_LO: begin
                        if (accept) begin
                            count_q <= hdr_count;
                            idle_q  <= '0;
                            if (hdr_count == '0) begin
                                state_q    <= DONE;
                                rx_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                                cpu_rst_q  <= 1'b0;
                            end else if ({1'b0, hdr_count} > DEPTH_LIMIT) begin
                                state_q    <= ERR;
                                rx_ready_q <= 1'b0;
                                err_q      <= 1'b1;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            idle_q <= idle_d;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            idle_q <= '0;
                            if (word_complete) begin
                                state_q      <= WRITE;
                                rx_ready_q   <= 1'b0;
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_addr(word_idx_q);
                                imem_wdata_q <= next_word;
                            end
                        end else begin
                            idle_q <= idle_d;
                        end
                    end
                    WRITE: begin
                        word_idx_q <= word_idx_d;
                        if (word_idx_d == count_q) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q    <= DATA;
                            rx_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a per-cycle vector table for the basic load,
// then hand-written sequences for empty/oversized headers, timeout and reset.
module tb_inst_loader;

    localparam int TO = 20;

    logic clk;
    logic rst;
    logic start;
    logic cpu_rst;
    logic done;
    logic err;

    inst_loader_if bus ();

    inst_loader #(
        .DEPTH_WORDS (1024),
        .TIMEOUT     (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] wlog[$];
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});
    end

    typedef struct {
        logic        start;
        logic        vld;
        logic [7:0]  data;
        logic [68:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [68:0] ev(input logic rdy, input logic we, input logic dn,
                                       input logic er, input logic cr,
                                       input logic [31:0] a, input logic [31:0] d);
        return {rdy, we, dn, er, cr, a, d};
    endfunction

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic [68:0] e);
        vec_t r;
        r.start = s;
        r.vld   = v;
        r.data  = d;
        r.exp   = e;
        return r;
    endfunction

    function automatic logic [68:0] snap();
        return {bus.rx_ready, bus.imem_we, done, err, cpu_rst, bus.imem_addr, bus.imem_wdata};
    endfunction

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d);
        start        = s;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Idle for 'gap' cycles (optionally with start noise), then hold the byte until taken.
    task automatic send_byte(input logic [7:0] d, input int gap, input bit noise);
        int n;
        for (int i = 0; i < gap; i++) begin
            drive(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 8'h00);
        end
        start        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_ready got %b want 1", bus.rx_ready);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    logic [7:0] stream[10];
    int         n;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};

        tbl[0]  = mk(1, 0, 8'h00, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[1]  = mk(0, 1, 8'h00, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[2]  = mk(0, 1, 8'h02, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[3]  = mk(0, 1, 8'h20, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[4]  = mk(0, 1, 8'h08, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[5]  = mk(0, 1, 8'h00, ev(1, 0, 0, 0, 1, 32'h0, 32'h0));
        tbl[6]  = mk(0, 1, 8'h05, ev(0, 1, 0, 0, 1, 32'h0, 32'h20080005));
        tbl[7]  = mk(0, 1, 8'hAC, ev(1, 0, 0, 0, 1, 32'h0, 32'h20080005));
        tbl[8]  = mk(0, 1, 8'hAC, ev(1, 0, 0, 0, 1, 32'h0, 32'h20080005));
        tbl[9]  = mk(0, 1, 8'h08, ev(1, 0, 0, 0, 1, 32'h0, 32'h20080005));
        tbl[10] = mk(0, 1, 8'h00, ev(1, 0, 0, 0, 1, 32'h0, 32'h20080005));
        tbl[11] = mk(0, 1, 8'h00, ev(0, 1, 0, 0, 1, 32'h4, 32'hAC080000));
        tbl[12] = mk(0, 0, 8'h00, ev(0, 0, 1, 0, 0, 32'h4, 32'hAC080000));
        tbl[13] = mk(0, 0, 8'h00, ev(0, 0, 1, 0, 0, 32'h4, 32'hAC080000));

        rst = 1'b1;
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        rst = 1'b0;
        chk("reset_state", snap(), ev(0, 0, 0, 0, 1, 32'h0, 32'h0));

        // Basic two-word load with rx_valid held high
        wlog.delete();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].start, tbl[i].vld, tbl[i].data);
            chk($sformatf("vec%0d", i), snap(), tbl[i].exp);
        end
        chk("basic_nwrites", 69'(wlog.size()), 69'd2);
        if (wlog.size() >= 2) begin
            chk("basic_wr0", 69'(wlog[0]), 69'({32'h0, 32'h20080005}));
            chk("basic_wr1", 69'(wlog[1]), 69'({32'h4, 32'hAC080000}));
        end

        // Zero-length header
        wlog.delete();
        drive(1, 0, 8'h00);
        chk("zero_restart", snap(), ev(1, 0, 0, 0, 1, 32'h4, 32'hAC080000));
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        chk("zero_done", snap(), ev(0, 0, 1, 0, 0, 32'h4, 32'hAC080000));
        drive(0, 0, 8'h00);
        chk("zero_done_hold", snap(), ev(0, 0, 1, 0, 0, 32'h4, 32'hAC080000));
        chk("zero_nwrites", 69'(wlog.size()), 69'd0);

        // Oversized header: 0x0401 = 1025 words
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h01);
        chk("big_err", snap(), ev(0, 0, 0, 1, 1, 32'h4, 32'hAC080000));
        drive(0, 1, 8'h55);
        chk("big_err_hold", snap(), ev(0, 0, 0, 1, 1, 32'h4, 32'hAC080000));
        chk("big_nwrites", 69'(wlog.size()), 69'd0);

        // Timeout after three data bytes of a one-word load
        drive(1, 0, 8'h00);
        chk("to_restart", snap(), ev(1, 0, 0, 0, 1, 32'h4, 32'hAC080000));
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h22);
        drive(0, 1, 8'h33);
        for (int i = 0; i < TO - 1; i++) drive(0, 0, 8'h00);
        chk("to_before", snap(), ev(1, 0, 0, 0, 1, 32'h4, 32'hAC080000));
        drive(0, 0, 8'h00);
        chk("to_err", snap(), ev(0, 0, 0, 1, 1, 32'h4, 32'hAC080000));
        drive(0, 1, 8'h44);
        chk("to_nwrites", 69'(wlog.size()), 69'd0);

        // Reset in the middle of a word
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h22);
        rst = 1'b1;
        drive(0, 1, 8'h33);
        rst = 1'b0;
        chk("rst_mid", snap(), ev(0, 0, 0, 0, 1, 32'h0, 32'h0));
        drive(0, 1, 8'h44);
        drive(0, 1, 8'h55);
        chk("rst_idle_hold", snap(), ev(0, 0, 0, 0, 1, 32'h0, 32'h0));
        chk("rst_nwrites", 69'(wlog.size()), 69'd0);

        // Reload with random gaps and start noise while loading
        drive(1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            send_byte(stream[i], int'($urandom_range(0, 5)), 1'b1);
        end
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            drive(0, 0, 8'h00);
            n++;
        end
        chk("gap_done", snap(), ev(0, 0, 1, 0, 0, 32'h4, 32'hAC080000));
        chk("gap_nwrites", 69'(wlog.size()), 69'd2);
        if (wlog.size() >= 2) begin
            chk("gap_wr0", 69'(wlog[0]), 69'({32'h0, 32'h20080005}));
            chk("gap_wr1", 69'(wlog[1]), 69'({32'h4, 32'hAC080000}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
